// File: rtl/fp_unpack_if.sv
// Operand/result bundle for fp_unpack. The master side feeds operands and
// takes results; the slave side is the unpack unit itself.
interface fp_unpack_if #(
  parameter int FPWID = 128
);

  localparam int EMSB = (FPWID == 128) ? 14 :
                        (FPWID == 96)  ? 14 :
                        (FPWID == 80)  ? 14 :
                        (FPWID == 64)  ? 10 :
                        (FPWID == 48)  ? 10 :
                        (FPWID == 40)  ? 9  :
                        (FPWID == 32)  ? 7  :
                        (FPWID == 24)  ? 6  :
                        (FPWID == 16)  ? 4  : 14;
  localparam int FMSB = FPWID - EMSB - 3;
  localparam int MSB  = FPWID - 1;

  logic [FPWID-1:0] i;
  logic             i_v;
  logic             i_rdy;
  logic [MSB+3:0]   o;
  logic [FMSB+1:0]  nm;
  logic [EMSB+2:0]  nx;
  logic             o_v;
  logic             o_rdy;
  logic             zero;
  logic             dnm;
  logic             inf;
  logic             qnan;
  logic             snan;

  modport master (
    output i, i_v, o_rdy,
    input  i_rdy, o, nm, nx, o_v, zero, dnm, inf, qnan, snan
  );

  modport slave (
    input  i, i_v, o_rdy,
    output i_rdy, o, nm, nx, o_v, zero, dnm, inf, qnan, snan
  );

endinterface

// File: rtl/fp_unpack.sv
// Floating-point unpack/normalise unit. Classifies an IEEE operand, emits it
// in the rounder's expanded format and as a normalised mantissa/exponent
// pair. Denormals are normalised one bit per enabled cycle.
module fp_unpack #(
  parameter int FPWID = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  fp_unpack_if.slave  bus
);

  localparam int EMSB = (FPWID == 128) ? 14 :
                        (FPWID == 96)  ? 14 :
                        (FPWID == 80)  ? 14 :
                        (FPWID == 64)  ? 10 :
                        (FPWID == 48)  ? 10 :
                        (FPWID == 40)  ? 9  :
                        (FPWID == 32)  ? 7  :
                        (FPWID == 24)  ? 6  :
                        (FPWID == 16)  ? 4  : 14;
  localparam int FMSB = FPWID - EMSB - 3;
  localparam int MSB  = FPWID - 1;

  localparam logic [EMSB+2:0] NX_ONE = {{(EMSB+2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             i_rdy_q;
  logic             o_v_q;
  logic [MSB+3:0]   o_q;
  logic [FMSB+1:0]  nm_q;
  logic [EMSB+2:0]  nx_q;
  logic             zero_q;
  logic             dnm_q;
  logic             inf_q;
  logic             qnan_q;
  logic             snan_q;

  // Operand fields and class of the presented input
  logic             s_w;
  logic [EMSB:0]    e_w;
  logic [FMSB:0]    f_w;
  logic             e_zero_w;
  logic             e_ones_w;
  logic             f_zero_w;
  logic             zero_w;
  logic             dnm_w;
  logic             inf_w;
  logic             qnan_w;
  logic             snan_w;

  // Values loaded on accept
  logic [MSB+3:0]   o_d;
  logic [FMSB+1:0]  nm_d;
  logic [EMSB+2:0]  nx_d;

  logic             accept_w;
  logic [FMSB+1:0]  nm_shift_w;

  assign s_w      = bus.i[MSB];
  assign e_w      = bus.i[MSB-1:FMSB+1];
  assign f_w      = bus.i[FMSB:0];
  assign e_zero_w = (e_w == '0);
  assign e_ones_w = &e_w;
  assign f_zero_w = (f_w == '0);

  assign zero_w   = e_zero_w & f_zero_w;
  assign dnm_w    = e_zero_w & ~f_zero_w;
  assign inf_w    = e_ones_w & f_zero_w;
  assign qnan_w   = e_ones_w & f_w[FMSB];
  assign snan_w   = e_ones_w & ~f_zero_w & ~f_w[FMSB];

  assign accept_w   = ce & bus.i_v & i_rdy_q;
  assign nm_shift_w = {nm_q[FMSB:0], 1'b0};

  // Build the expanded word and the initial normalised pair for the input
  always_comb begin
    o_d  = '0;
    nm_d = '0;
    nx_d = '0;
    if (zero_w) begin
      o_d  = {s_w, e_w, f_w, 3'b000};
      nm_d = '0;
      nx_d = '0;
    end else if (dnm_w) begin
      o_d  = {s_w, e_w, f_w, 3'b000};
      nm_d = {1'b0, f_w};
      nx_d = NX_ONE;
    end else if (e_ones_w) begin
      o_d  = {s_w, e_w, 1'b1, f_w, 2'b00};
      nm_d = {1'b0, f_w};
      nx_d = {2'b00, e_w};
    end else begin
      o_d  = {s_w, e_w, 1'b1, f_w, 2'b00};
      nm_d = {1'b1, f_w};
      nx_d = {2'b00, e_w};
    end
  end

  // Control FSM and result registers, all frozen while ce is low.
  // Every operand passes through NORM; only denormals shift there, so
  // non-denormals see one cycle of latency and denormals one per shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_rdy_q <= 1'b1;
      o_v_q   <= 1'b0;
      o_q     <= '0;
      nm_q    <= '0;
      nx_q    <= '0;
      zero_q  <= 1'b0;
      dnm_q   <= 1'b0;
      inf_q   <= 1'b0;
      qnan_q  <= 1'b0;
      snan_q  <= 1'b0;
    end else if (ce) begin
      case (state_q)
        IDLE: begin
          if (accept_w) begin
            o_q     <= o_d;
            nm_q    <= nm_d;
            nx_q    <= nx_d;
            zero_q  <= zero_w;
            dnm_q   <= dnm_w;
            inf_q   <= inf_w;
            qnan_q  <= qnan_w;
            snan_q  <= snan_w;
            state_q <= NORM;
            i_rdy_q <= 1'b0;
            o_v_q   <= 1'b0;
          end
        end
        NORM: begin
          if (dnm_q) begin
            nm_q <= nm_shift_w;
            nx_q <= nx_q - NX_ONE;
            if (nm_shift_w[FMSB+1]) begin
              state_q <= DONE;
              o_v_q   <= 1'b1;
            end
          end else begin
            state_q <= DONE;
            o_v_q   <= 1'b1;
          end
        end
        DONE: begin
          if (bus.o_rdy) begin
            state_q <= IDLE;
            o_v_q   <= 1'b0;
            i_rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          o_v_q   <= 1'b0;
          i_rdy_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.i_rdy = i_rdy_q;
  assign bus.o_v   = o_v_q;
  assign bus.o     = o_q;
  assign bus.nm    = nm_q;
  assign bus.nx    = nx_q;
  assign bus.zero  = zero_q;
  assign bus.dnm   = dnm_q;
  assign bus.inf   = inf_q;
  assign bus.qnan  = qnan_q;
  assign bus.snan  = snan_q;

endmodule

// File: tb/tb_fp_unpack.sv
// Directed bench for fp_unpack at FPWID=32 with hand-computed expectations.
module tb_fp_unpack;

  logic clk;
  logic rst;
  logic ce;

  int checks;
  int errors;
  int n;

  fp_unpack_if #(.FPWID(32)) bus ();

  fp_unpack #(.FPWID(32)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.zero, bus.dnm, bus.inf, bus.qnan, bus.snan};
  endfunction

  task automatic issue(input logic [31:0] v);
    bus.i   = v;
    bus.i_v = 1'b1;
    tick();
    bus.i_v = 1'b0;
    check("accept_irdy", bus.i_rdy, 64'd0);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.o_v !== 1'b1 && cyc < 64) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_result();
    bus.o_rdy = 1'b1;
    tick();
    bus.o_rdy = 1'b0;
    check("release_irdy", bus.i_rdy, 64'd1);
    check("release_ov", bus.o_v, 64'd0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    ce         = 1'b1;
    bus.i      = '0;
    bus.i_v    = 1'b0;
    bus.o_rdy  = 1'b0;

    // Reset state
    #3;
    check("rst_irdy", bus.i_rdy, 64'd1);
    check("rst_ov", bus.o_v, 64'd0);
    check("rst_o", bus.o, 64'd0);
    check("rst_nm", bus.nm, 64'd0);
    check("rst_nx", bus.nx, 64'd0);
    check("rst_flags", flags(), 64'd0);
    #4;
    rst = 1'b0;
    tick();

    // 1.0
    issue(32'h3F80_0000);
    wait_done(n);
    check("one_lat", n, 64'd1);
    check("one_o", bus.o, 64'h1_FE00_0000);
    check("one_nm", bus.nm, 64'h80_0000);
    check("one_nx", bus.nx, 64'd127);
    check("one_flags", flags(), 64'd0);
    release_result();

    // Smallest denormal
    issue(32'h0000_0001);
    wait_done(n);
    check("dmin_lat", n, 64'd23);
    check("dmin_o", bus.o, 64'h8);
    check("dmin_nm", bus.nm, 64'h80_0000);
    check("dmin_nx", bus.nx, 64'h3EA);
    check("dmin_flags", flags(), 64'b01000);
    release_result();

    // Largest-leading-bit negative denormal, one shift
    issue(32'h8040_0000);
    wait_done(n);
    check("dmax_lat", n, 64'd1);
    check("dmax_o", bus.o, 64'h4_0200_0000);
    check("dmax_nm", bus.nm, 64'h80_0000);
    check("dmax_nx", bus.nx, 64'd0);
    check("dmax_flags", flags(), 64'b01000);
    release_result();

    // Quiet NaN
    issue(32'h7FC0_0000);
    wait_done(n);
    check("qnan_lat", n, 64'd1);
    check("qnan_o", bus.o, 64'h3_FF00_0000);
    check("qnan_nm", bus.nm, 64'h40_0000);
    check("qnan_nx", bus.nx, 64'hFF);
    check("qnan_flags", flags(), 64'b00010);
    release_result();

    // Signalling NaN
    issue(32'h7F80_0001);
    wait_done(n);
    check("snan_lat", n, 64'd1);
    check("snan_o", bus.o, 64'h3_FE00_0004);
    check("snan_nm", bus.nm, 64'h1);
    check("snan_flags", flags(), 64'b00001);
    release_result();

    // Negative infinity
    issue(32'hFF80_0000);
    wait_done(n);
    check("inf_lat", n, 64'd1);
    check("inf_o", bus.o, 64'h7_FE00_0000);
    check("inf_nm", bus.nm, 64'h0);
    check("inf_nx", bus.nx, 64'hFF);
    check("inf_flags", flags(), 64'b00100);
    release_result();

    // Zero
    issue(32'h0000_0000);
    wait_done(n);
    check("zero_lat", n, 64'd1);
    check("zero_o", bus.o, 64'h0);
    check("zero_nm", bus.nm, 64'h0);
    check("zero_nx", bus.nx, 64'h0);
    check("zero_flags", flags(), 64'b10000);
    release_result();

    // Backpressure: result held, new operands ignored
    issue(32'h3F80_0000);
    wait_done(n);
    check("bp_lat", n, 64'd1);
    for (int k = 0; k < 5; k++) begin
      bus.i   = 32'h4000_0000;
      bus.i_v = 1'b1;
      tick();
      check("bp_ov", bus.o_v, 64'd1);
      check("bp_irdy", bus.i_rdy, 64'd0);
      check("bp_o", bus.o, 64'h1_FE00_0000);
      check("bp_nx", bus.nx, 64'd127);
    end
    bus.i_v = 1'b0;
    release_result();
    check("bp_hold_o", bus.o, 64'h1_FE00_0000);

    // o_rdy held high: one cycle in DONE, then IDLE
    bus.o_rdy = 1'b1;
    issue(32'h4000_0000);
    wait_done(n);
    check("tp_lat", n, 64'd1);
    check("tp_o", bus.o, 64'h2_0200_0000);
    check("tp_nm", bus.nm, 64'h80_0000);
    check("tp_nx", bus.nx, 64'd128);
    tick();
    check("tp_irdy", bus.i_rdy, 64'd1);
    check("tp_ov", bus.o_v, 64'd0);
    bus.o_rdy = 1'b0;

    // Reset during normalisation
    issue(32'h0000_0001);
    for (int k = 0; k < 5; k++) tick();
    check("mid_ov", bus.o_v, 64'd0);
    check("mid_nm", bus.nm, 64'h20);
    check("mid_nx", bus.nx, 64'h3FC);
    rst = 1'b1;
    #1;
    check("arst_ov", bus.o_v, 64'd0);
    check("arst_irdy", bus.i_rdy, 64'd1);
    check("arst_o", bus.o, 64'd0);
    check("arst_nm", bus.nm, 64'd0);
    check("arst_nx", bus.nx, 64'd0);
    check("arst_flags", flags(), 64'd0);
    #1;
    rst = 1'b0;
    tick();

    // Clock enable held low mid-normalisation
    issue(32'h0000_0001);
    for (int k = 0; k < 5; k++) tick();
    ce = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("ce_ov", bus.o_v, 64'd0);
    check("ce_nm", bus.nm, 64'h20);
    check("ce_nx", bus.nx, 64'h3FC);
    ce = 1'b1;
    wait_done(n);
    check("ce_lat", n + 9, 64'd27);
    check("ce_final_nm", bus.nm, 64'h80_0000);
    check("ce_final_nx", bus.nx, 64'h3EA);
    release_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
